display_mux_scheduler: RTL and testbench
========================================

DISPLAY_MUX_SCHEDULER -- requirements
Module: display_mux_scheduler

Interface
REQ-001 The block SHALL have parameter DWELL_CYCLES, default 10000, the number of clk cycles each digit is enabled per visit; legal range 1..65535.
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 100, the number of clk cycles both digits are disabled between visits; legal range 1..65535.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port in_digit, input, 4 bits: new hex value offered for display.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_digit is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept in_digit this cycle.
REQ-008 The block SHALL have port hex_out, output, 4 bits: the value sent to the shared seven-segment decoder.
REQ-009 The block SHALL have port selector1, output, 1 bit, active-high: enables digit 0 (right, most recent).
REQ-010 The block SHALL have port selector2, output, 1 bit, active-high: enables digit 1 (left, previous).
REQ-011 The block SHALL have port frame_tick, output, 1 bit: one-cycle pulse at the end of each full refresh frame.

Function
REQ-012 The block SHALL hold two 4-bit digit registers, d0 and d1, plus a 16-bit dwell counter and a 2-bit state.
REQ-013 The state machine SHALL cycle SHOW0 -> BLANK0 -> SHOW1 -> BLANK1 -> SHOW0 with no other transitions.
REQ-014 In SHOWx the counter SHALL count 0..DWELL_CYCLES-1; on DWELL_CYCLES-1 it SHALL advance the state and clear the counter.
REQ-015 In BLANKx the counter SHALL count 0..BLANK_CYCLES-1; on BLANK_CYCLES-1 it SHALL advance the state and clear the counter.
REQ-016 Full frame period SHALL be exactly 2*(DWELL_CYCLES+BLANK_CYCLES) cycles.
REQ-017 selector1 SHALL be 1 iff state==SHOW0; selector2 SHALL be 1 iff state==SHOW1. Both SHALL be 0 in blank states and never 1 together.
REQ-018 hex_out SHALL equal d0 in SHOW0 and BLANK1, and d1 in SHOW1 and BLANK0, so the decoder input settles before the enable rises.
REQ-019 in_ready SHALL be 1 only in BLANK0 or BLANK1.
REQ-020 On a cycle with in_valid and in_ready both 1, the block SHALL load d1<=d0 and d0<=in_digit at that clock edge.
REQ-021 When in_valid is 1 and in_ready is 0, the block SHALL NOT modify d0/d1; the value is held by the producer until a blank state.
REQ-022 hex_out SHALL reflect a new d0/d1 from the cycle after acceptance. The enabled digit's value SHALL never change during SHOWx.
REQ-023 frame_tick SHALL be 1 for exactly the single cycle in BLANK1 with counter==BLANK_CYCLES-1, else 0.
REQ-024 Counter and state SHALL wrap indefinitely, with no terminal state and no dependency on in_valid.

Reset
REQ-025 When reset==0 at a clk edge, the block SHALL set state=BLANK1, counter=0, d0=0, d1=0.
REQ-026 While in reset, outputs SHALL be selector1=0, selector2=0, hex_out=0, in_ready=1, frame_tick=0, and no transfer SHALL be accepted.
REQ-027 Reset asserted mid-SHOW SHALL disable both selectors on the next cycle and discard the frame position.
REQ-028 After reset is released, SHOW0 SHALL begin exactly BLANK_CYCLES cycles later.

Configuration
REQ-029 With macro DISPLAY_MUX_LEADING_ZERO_BLANK_EN defined, selector2 SHALL be held 0 during SHOW1 whenever d1==0. Timing and hex_out are unchanged.
REQ-030 Without DISPLAY_MUX_LEADING_ZERO_BLANK_EN, selector2 SHALL follow REQ-017 regardless of d1.

Verification (DWELL_CYCLES=4, BLANK_CYCLES=2)
REQ-031 The bench SHALL check reset release with in_valid=0 -> 2 cycles with both selectors 0, then selector1=1 for 4 cycles, 2 cycles blank, selector2=1 for 4 cycles, and frame_tick pulses every 12 cycles.
REQ-032 The bench SHALL check that in_digit=5 with in_valid held from the first SHOW0 cycle is accepted only in the first BLANK0 cycle -> d0=5, d1=0; hex_out=5 in the next SHOW0.
REQ-033 The bench SHALL check back-to-back transfers 3 then 7 in consecutive blank cycles -> d1=3, d0=7; SHOW1 displays 3 and SHOW0 displays 7.
REQ-034 The bench SHALL check reset=0 asserted in cycle 2 of SHOW1 -> next cycle selector2=0, hex_out=0, d0=d1=0; first SHOW0 2 cycles after release.
REQ-035 The bench SHALL check, with DISPLAY_MUX_LEADING_ZERO_BLANK_EN defined and d1=0, d0=9 -> selector2 stays 0 throughout SHOW1 and selector1=1 in SHOW0; after loading 4, selector2 is active again.
REQ-036 The bench SHALL assert on every cycle that selector1 and selector2 are never both 1 and that hex_out is stable while either selector is 1.

Source files
------------

// File: rtl/display_mux_scheduler.sv
// rtl/display_mux_scheduler.sv - two-digit time-multiplexed seven-segment scheduler with blanking gaps
// Optional: define DISPLAY_MUX_LEADING_ZERO_BLANK_EN to suppress a zero left digit.
module display_mux_scheduler #(
    parameter int DWELL_CYCLES = 10000,
    parameter int BLANK_CYCLES = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] in_digit,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] hex_out,
    output logic       selector1,
    output logic       selector2,
    output logic       frame_tick
);

    typedef enum logic [1:0] {
        SHOW0  = 2'd0,
        BLANK0 = 2'd1,
        SHOW1  = 2'd2,
        BLANK1 = 2'd3
    } state_t;

    localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] count;
    logic [15:0] count_next;
    logic [3:0]  d0;
    logic [3:0]  d1;
    logic        last;
    logic        accept;

    always_comb begin
        last = 1'b0;
        case (state)
            SHOW0, SHOW1: last = (count == DWELL_LAST);
            default:      last = (count == BLANK_LAST);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= BLANK1;
            count <= 16'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count + 16'd1;
        if (last) begin
            count_next = 16'd0;
            case (state)
                SHOW0:   state_next = BLANK0;
                BLANK0:  state_next = SHOW1;
                SHOW1:   state_next = BLANK1;
                default: state_next = SHOW0;
            endcase
        end
    end

    // Digits only move during blank gaps, so a lit digit never changes value.
    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            d0 <= 4'd0;
            d1 <= 4'd0;
        end else if (accept) begin
            d1 <= d0;
            d0 <= in_digit;
        end
    end

    // Each blank shows the digit lit next, so the decoder settles before its enable rises.
    always_comb begin
        selector1  = 1'b0;
        selector2  = 1'b0;
        in_ready   = 1'b0;
        hex_out    = d0;
        frame_tick = 1'b0;
        case (state)
            SHOW0: begin
                selector1 = 1'b1;
                hex_out   = d0;
            end
            BLANK0: begin
                in_ready = 1'b1;
                hex_out  = d1;
            end
            SHOW1: begin
`ifdef DISPLAY_MUX_LEADING_ZERO_BLANK_EN
                selector2 = (d1 != 4'd0);
`else
                selector2 = 1'b1;
`endif
                hex_out   = d1;
            end
            default: begin
                in_ready   = 1'b1;
                hex_out    = d0;
                frame_tick = last && reset;
            end
        endcase
    end

endmodule

// File: tb/tb_display_mux_scheduler.sv
// tb/tb_display_mux_scheduler.sv - directed self-checking bench for display_mux_scheduler (DWELL=4, BLANK=2)
module tb_display_mux_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in_digit;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] hex_out;
    logic       selector1;
    logic       selector2;
    logic       frame_tick;

    int tests = 0;
    int fails = 0;
    int phase = 0;

    display_mux_scheduler #(
        .DWELL_CYCLES(4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_digit  (in_digit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .hex_out   (hex_out),
        .selector1 (selector1),
        .selector2 (selector2),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Frame phase after reset release: 0-1 BLANK1, 2-5 SHOW0, 6-7 BLANK0, 8-11 SHOW1.
    task automatic tick;
        logic       p_s1;
        logic       p_s2;
        logic [3:0] p_hex;
        p_s1  = selector1;
        p_s2  = selector2;
        p_hex = hex_out;
        @(posedge clk);
        #1;
        phase = (phase + 1) % 12;
        tests++;
        if (selector1 === 1'b1 && selector2 === 1'b1) begin
            fails++;
            $display("FAIL sel_exclusive: selector1=%b selector2=%b, required not both 1", selector1, selector2);
        end
        tests++;
        if (((p_s1 && selector1) || (p_s2 && selector2)) && hex_out !== p_hex) begin
            fails++;
            $display("FAIL hex_stable: hex_out=%h while lit, required %h", hex_out, p_hex);
        end
    endtask

    task automatic do_reset;
        in_valid = 1'b0;
        reset    = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        phase = 0;
    endtask

    task automatic advance_to(input int p);
        for (int i = 0; i < 12 && phase != p; i++) tick();
    endtask

    task automatic test_reset;
        reset    = 1'b0;
        in_valid = 1'b1;
        in_digit = 4'hF;
        tick();
        tick();
        tests++;
        if (selector1 !== 1'b0) begin fails++; $display("FAIL rst_sel1: got %b, required 0", selector1); end
        tests++;
        if (selector2 !== 1'b0) begin fails++; $display("FAIL rst_sel2: got %b, required 0", selector2); end
        tests++;
        if (hex_out !== 4'h0) begin fails++; $display("FAIL rst_hex: got %h, required 0", hex_out); end
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b, required 1", in_ready); end
        tests++;
        if (frame_tick !== 1'b0) begin fails++; $display("FAIL rst_tick: got %b, required 0", frame_tick); end
        in_valid = 1'b0;
    endtask

    task automatic test_frame;
        logic e_s1, e_s2, e_tick, e_rdy;
        int p;
        reset = 1'b1;
        phase = 0;
        for (int i = 0; i < 26; i++) begin
            p      = i % 12;
            e_s1   = (p >= 2 && p <= 5);
            e_s2   = (p >= 8 && p <= 11);
            e_tick = (p == 1);
            e_rdy  = (p <= 1) || (p == 6) || (p == 7);
            tests++;
            if ({selector1, selector2, frame_tick, in_ready, hex_out} !== {e_s1, e_s2, e_tick, e_rdy, 4'h0}) begin
                fails++;
                $display("FAIL frame_cycle%0d: s1/s2/tick/rdy/hex=%b%b%b%b/%h, required %b%b%b%b/0",
                         i, selector1, selector2, frame_tick, in_ready, hex_out, e_s1, e_s2, e_tick, e_rdy);
            end
            if (i != 25) tick();
        end
    endtask

    task automatic test_accept_in_blank;
        do_reset();
        advance_to(2);
        in_digit = 4'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (hex_out !== 4'd0 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL hold_show0_%0d: hex=%h rdy=%b, required hex=0 rdy=0", i, hex_out, in_ready);
            end
            tick();
        end
        tests++;
        if (phase != 6 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_blank0: phase=%0d rdy=%b, required phase 6 rdy=1", phase, in_ready);
        end
        tick();
        in_valid = 1'b0;
        tests++;
        if (hex_out !== 4'd0) begin fails++; $display("FAIL acc_blank0_d1: hex=%h, required 0", hex_out); end
        tick();
        tests++;
        if (hex_out !== 4'd0 || selector2 !== 1'b1) begin
            fails++;
            $display("FAIL acc_show1_d1: hex=%h sel2=%b, required hex=0 sel2=1", hex_out, selector2);
        end
        advance_to(2);
        tests++;
        if (hex_out !== 4'd5 || selector1 !== 1'b1) begin
            fails++;
            $display("FAIL acc_show0_d0: hex=%h sel1=%b, required hex=5 sel1=1", hex_out, selector1);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        advance_to(6);
        in_valid = 1'b1;
        in_digit = 4'd3;
        tick();
        in_digit = 4'd7;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (hex_out !== 4'd3 || selector2 !== 1'b1) begin
                fails++;
                $display("FAIL b2b_show1_%0d: hex=%h sel2=%b, required hex=3 sel2=1", i, hex_out, selector2);
            end
            tick();
        end
        advance_to(2);
        tests++;
        if (hex_out !== 4'd7 || selector1 !== 1'b1) begin
            fails++;
            $display("FAIL b2b_show0: hex=%h sel1=%b, required hex=7 sel1=1", hex_out, selector1);
        end
    endtask

    task automatic test_reset_mid_show;
        advance_to(9);
        reset = 1'b0;
        tests++;
        if (selector2 !== 1'b1) begin fails++; $display("FAIL mid_pre: sel2=%b, required 1", selector2); end
        tick();
        tests++;
        if ({selector1, selector2, in_ready, frame_tick, hex_out} !== {1'b0, 1'b0, 1'b1, 1'b0, 4'h0}) begin
            fails++;
            $display("FAIL mid_reset: s1/s2/rdy/tick/hex=%b%b%b%b/%h, required 0010/0",
                     selector1, selector2, in_ready, frame_tick, hex_out);
        end
        tick();
        reset = 1'b1;
        phase = 0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (selector1 !== (i == 2)) begin
                fails++;
                $display("FAIL mid_release%0d: sel1=%b, required %b", i, selector1, (i == 2));
            end
            if (i != 2) tick();
        end
        tests++;
        if (hex_out !== 4'd0) begin fails++; $display("FAIL mid_d0: hex=%h, required 0", hex_out); end
        advance_to(8);
        tests++;
        if (hex_out !== 4'd0) begin fails++; $display("FAIL mid_d1: hex=%h, required 0", hex_out); end
    endtask

    task automatic test_leading_zero;
        logic e_s2;
`ifdef DISPLAY_MUX_LEADING_ZERO_BLANK_EN
        e_s2 = 1'b0;
`else
        e_s2 = 1'b1;
`endif
        do_reset();
        advance_to(6);
        in_valid = 1'b1;
        in_digit = 4'd9;
        tick();
        in_valid = 1'b0;
        advance_to(8);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (selector2 !== e_s2 || hex_out !== 4'd0) begin
                fails++;
                $display("FAIL lz_show1_%0d: sel2=%b hex=%h, required sel2=%b hex=0", i, selector2, hex_out, e_s2);
            end
            tick();
        end
        advance_to(2);
        tests++;
        if (selector1 !== 1'b1 || hex_out !== 4'd9) begin
            fails++;
            $display("FAIL lz_show0: sel1=%b hex=%h, required sel1=1 hex=9", selector1, hex_out);
        end
        advance_to(6);
        in_valid = 1'b1;
        in_digit = 4'd4;
        tick();
        in_valid = 1'b0;
        advance_to(8);
        tests++;
        if (selector2 !== 1'b1 || hex_out !== 4'd9) begin
            fails++;
            $display("FAIL lz_reload: sel2=%b hex=%h, required sel2=1 hex=9", selector2, hex_out);
        end
        advance_to(2);
        tests++;
        if (selector1 !== 1'b1 || hex_out !== 4'd4) begin
            fails++;
            $display("FAIL lz_reload_d0: sel1=%b hex=%h, required sel1=1 hex=4", selector1, hex_out);
        end
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_digit = 4'd0;
        test_reset();
        test_frame();
        test_accept_in_blank();
        test_back_to_back();
        test_reset_mid_show();
        test_leading_zero();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
